// File: rtl/sd_sektor_schreiber.sv
// sd_sektor_schreiber: collects bus words into a one-sector buffer and streams it as a 512-byte SD block write
module sd_sektor_schreiber (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Adresse,
    input  logic [31:0] Daten,
    input  logic        Schreiben,
    input  logic        Leeren,
    output logic        Angenommen,
    output logic        Fertig,
    output logic        Busy,
    input  logic        sd_ready,
    input  logic        sd_rfnb,
    output logic        sd_wr,
    output logic [7:0]  sd_din,
    output logic [31:0] sd_address
);
    localparam int WORTE = 128;
    typedef enum logic [2:0] {LEER, SAMMELN, WARTEN, SENDEN, ABSCHLUSS} zustand_t;
    zustand_t         state_q, state_d;
    logic [WORTE-1:0] valid_q, valid_d;
    logic [22:0]      tag_q, tag_d;
    logic [8:0]       bz_q, bz_d;
    logic [31:0]      addr_q, addr_d;
    logic             ack_q, ack_d;
    logic             fertig_q, fertig_d;
    logic [31:0]      mem [WORTE];
    logic [31:0]      rd_q;
    logic [6:0]       slot;
    logic             we, annahme, tag_gleich;
    logic             unused_adresse;

    assign slot           = Adresse[6:0];
    assign annahme        = Schreiben && !ack_q;
    assign tag_gleich     = Adresse[29:7] == tag_q;
    assign unused_adresse = ^Adresse[31:30];
    assign Angenommen     = ack_q;
    assign Fertig         = fertig_q;
    assign Busy           = (state_q == WARTEN) || (state_q == SENDEN) || (state_q == ABSCHLUSS);
    assign sd_wr          = state_q == SENDEN;
    assign sd_address     = addr_q;
    assign sd_din         = (sd_wr && valid_q[bz_q[8:2]]) ? rd_q[{~bz_q[1:0], 3'b000} +: 8] : 8'h00;

    // sequencing: collect words, commit on flush/full/foreign tag, stream bytes, wait for the card
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        bz_d     = bz_q;
        addr_d   = addr_q;
        ack_d    = 1'b0;
        fertig_d = 1'b0;
        we       = 1'b0;
        case (state_q)
            LEER: begin
                if (annahme) begin
                    tag_d         = Adresse[29:7];
                    valid_d[slot] = 1'b1;
                    we            = 1'b1;
                    ack_d         = 1'b1;
                    state_d       = SAMMELN;
                end
            end
            SAMMELN: begin
                if (&valid_q) begin
                    state_d = WARTEN;
                end else if (annahme && tag_gleich) begin
                    valid_d[slot] = 1'b1;
                    we            = 1'b1;
                    ack_d         = 1'b1;
                    state_d       = Leeren ? WARTEN : SAMMELN;
                end else if (annahme || Leeren) begin
                    state_d = WARTEN;
                end
            end
            WARTEN: begin
                bz_d = '0;
                if (sd_ready) begin
                    addr_d  = {tag_q, 9'b0};
                    state_d = SENDEN;
                end
            end
            SENDEN: begin
                if (sd_rfnb) begin
                    if (&bz_q) state_d = ABSCHLUSS;
                    else bz_d = bz_q + 9'd1;
                end
            end
            ABSCHLUSS: begin
                if (sd_ready) begin
                    fertig_d = 1'b1;
                    valid_d  = '0;
                    state_d  = LEER;
                end
            end
            default: state_d = LEER;
        endcase
    end

    // sector buffer; the read follows the next byte counter so sd_din is current without lag
    always_ff @(posedge Clock) begin
        if (we) mem[slot] <= Daten;
        rd_q <= mem[bz_d[8:2]];
    end

    // control registers with asynchronous clear
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= LEER;
            valid_q  <= '0;
            tag_q    <= '0;
            bz_q     <= '0;
            addr_q   <= '0;
            ack_q    <= 1'b0;
            fertig_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            bz_q     <= bz_d;
            addr_q   <= addr_d;
            ack_q    <= ack_d;
            fertig_q <= fertig_d;
        end
    end
endmodule
